// File: rtl/sd_seq_gen_pkg.sv
// Shared constants for the sd_seq_gen sequence producer: FSM state encoding
// and the 16-bit Fibonacci LFSR parameters used by the SD_SEQ_GEN_LFSR_EN build.
package sd_seq_gen_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 expressed for a right-shifting register (bits 0,2,3,5).
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/sd_lfsr16.sv
// 16-bit Fibonacci LFSR, stepped once per enable; used as the srdy throttle
// source when SD_SEQ_GEN_LFSR_EN is defined.
module sd_lfsr16
  import sd_seq_gen_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic [15:0] state
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= LFSR_SEED;
    end else if (en) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/sd_seq_gen.sv
// Incrementing-sequence producer with a pattern-throttled srdy/drdy output.
// Define SD_SEQ_GEN_LFSR_EN to throttle from an internal LFSR instead of srdy_pat.
//
// Handshake: p_srdy/p_drdy valid/ready. A transfer happens on a rising clk
// edge where p_srdy & p_drdy; once p_srdy is raised it and p_data are held
// until that transfer (no retraction).
module sd_seq_gen
  import sd_seq_gen_pkg::*;
#(
  parameter int width   = 8,
  parameter int pat_dep = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               gen_en,
  input  logic [15:0]        gen_count,
  input  logic [width-1:0]   seed,
  input  logic [pat_dep-1:0] srdy_pat,
  output logic               p_srdy,
  input  logic               p_drdy,
  output logic [width-1:0]   p_data,
  output logic [15:0]        sent_cnt,
  output logic               done,
  output logic [1:0]         state_dbg
);

  localparam int PTR_W = (pat_dep > 1) ? $clog2(pat_dep) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(pat_dep - 1);

  state_t           state;
  logic [PTR_W-1:0] ptr;
  logic [15:0]      count_q;
  logic             xfer;
  logic             advance;
  logic             last_item;
  logic             pat_step;
  logic             throttle;
  logic [15:0]      sent_inc;

  always_comb begin
    xfer      = p_srdy & p_drdy;
    advance   = (state == ST_RUN) && (!p_srdy || xfer);
    sent_inc  = sent_cnt + 16'd1;
    last_item = xfer && (count_q != 16'd0) && (sent_inc == count_q);
    // A pattern position is consumed only when a new srdy decision is taken.
    pat_step  = advance && gen_en && !last_item;
  end

`ifdef SD_SEQ_GEN_LFSR_EN
  logic [15:0] lfsr_state;

  sd_lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (pat_step),
    .state (lfsr_state)
  );

  assign throttle = lfsr_state[0];
`else
  assign throttle = srdy_pat[ptr];
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      p_srdy   <= 1'b0;
      p_data   <= '0;
      sent_cnt <= '0;
      done     <= 1'b0;
      ptr      <= '0;
      count_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          p_srdy <= 1'b0;
          if (gen_en) begin
            state    <= ST_RUN;
            p_data   <= seed;
            sent_cnt <= '0;
            ptr      <= '0;
            count_q  <= gen_count;
            done     <= 1'b0;
          end
        end

        ST_RUN: begin
          if (xfer) begin
            p_data   <= p_data + 1'b1;
            sent_cnt <= sent_inc;
          end
          if (last_item) begin
            state  <= ST_DONE;
            p_srdy <= 1'b0;
            done   <= 1'b1;
          end else if (advance) begin
            if (!gen_en) begin
              state  <= ST_IDLE;
              p_srdy <= 1'b0;
            end else begin
              p_srdy <= throttle;
              ptr    <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
            end
          end
        end

        ST_DONE: begin
          p_srdy <= 1'b0;
          if (!gen_en) begin
            state <= ST_IDLE;
            done  <= 1'b0;
          end
        end

        default: begin
          state  <= ST_IDLE;
          p_srdy <= 1'b0;
          done   <= 1'b0;
        end
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_sd_seq_gen.sv
// Scoreboard bench for sd_seq_gen: expected {sent_cnt, p_data} per transfer are
// queued at stimulus time and popped by an independent negedge monitor.
module tb_sd_seq_gen;
  import sd_seq_gen_pkg::*;

  localparam int W = 8;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         gen_en = 1'b0;
  logic [15:0]  gen_count = '0;
  logic [W-1:0] seed = '0;
  logic [D-1:0] srdy_pat = '0;
  logic         p_drdy = 1'b0;
  logic         p_srdy;
  logic [W-1:0] p_data;
  logic [15:0]  sent_cnt;
  logic         done;
  logic [1:0]   state_dbg;

  int total = 0;
  int bad = 0;
  int xfers = 0;
  logic [W+15:0] exp_q[$];

  sd_seq_gen #(.width(W), .pat_dep(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .gen_en    (gen_en),
    .gen_count (gen_count),
    .seed      (seed),
    .srdy_pat  (srdy_pat),
    .p_srdy    (p_srdy),
    .p_drdy    (p_drdy),
    .p_data    (p_data),
    .sent_cnt  (sent_cnt),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // With p_drdy held high every RUN edge takes a new pattern bit; the k-th set
  // bit of the repeating pattern (index q) is transferred at edge q+3 after start.
  function automatic int done_cycles(input logic [D-1:0] pat, input int n);
    int idx = 0;
    int found = 0;
    while (found < n) begin
      if (pat[idx % D]) found++;
      idx++;
    end
    return idx + 2;
  endfunction

  task automatic push_items(input logic [W-1:0] s, input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      logic [15:0]  c;
      logic [W-1:0] d;
      c = 16'(i);
      d = s + W'(i);
      exp_q.push_back({c, d});
    end
  endtask

  task automatic start_run(input logic [W-1:0] s, input logic [15:0] n,
                           input logic [D-1:0] pat, input bit push);
    seed = s;
    gen_count = n;
    srdy_pat = pat;
    gen_en = 1'b1;
    if (push) push_items(s, 0, int'(n));
  endtask

  task automatic wait_done(input int n, input int limit, input bit rnd, output int cyc);
    cyc = 0;
    while (!done && cyc < limit) begin
      if (rnd) p_drdy = 1'($urandom_range(0, 1));
      tick();
      cyc++;
    end
    check("done_seen", done, 1);
    check("done_srdy_low", p_srdy, 0);
    check("done_sent_cnt", sent_cnt, n);
    check("done_state", state_dbg, ST_DONE);
    check("done_queue_empty", exp_q.size(), 0);
  endtask

  task automatic finish_run();
    tick();
    check("done_hold", done, 1);
    check("done_hold_srdy", p_srdy, 0);
    gen_en = 1'b0;
    tick();
    check("done_clear", done, 0);
    check("idle_after_done", state_dbg, ST_IDLE);
  endtask

  task automatic wait_srdy();
    int c = 0;
    while (!p_srdy && c < 20) begin
      tick();
      c++;
    end
    check("srdy_seen", p_srdy, 1);
  endtask

  task automatic wait_queue_drain(input int limit);
    int c = 0;
    while (exp_q.size() != 0 && c < limit) begin
      tick();
      c++;
    end
    check("queue_drained", exp_q.size(), 0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic         hold;
    logic [W-1:0] hdata;
    logic [W+15:0] exp;
    hold = 1'b0;
    hdata = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          check("hold_srdy", p_srdy, 1);
          check("hold_data", p_data, hdata);
        end
        if (p_srdy && p_drdy) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_xfer: got data %0h cnt %0h expected none", p_data, sent_cnt);
          end else begin
            exp = exp_q.pop_front();
            check("xfer_cnt_data", {sent_cnt, p_data}, exp);
          end
          xfers++;
        end
        hold = p_srdy && !p_drdy;
        hdata = p_data;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    int x0;
    logic [W-1:0] s;
    logic [D-1:0] pat;
    logic [15:0] n;

    repeat (3) tick();
    check("rst_srdy", p_srdy, 0);
    check("rst_data", p_data, 0);
    check("rst_sent", sent_cnt, 0);
    check("rst_done", done, 0);
    check("rst_state", state_dbg, ST_IDLE);
    reset = 1'b1;
    repeat (2) tick();
    check("idle_no_run", state_dbg, ST_IDLE);

    // Back-to-back with all-ones pattern
    p_drdy = 1'b1;
    start_run(8'h10, 16'd4, 8'hFF, 1);
    wait_done(4, 100, 0, cyc);
    check("cycles_b2b", cyc, done_cycles(8'hFF, 4));
    finish_run();

    // Data wrap max->0
    start_run(8'hFE, 16'd3, 8'hFF, 1);
    wait_done(3, 100, 0, cyc);
    check("cycles_wrap", cyc, done_cycles(8'hFF, 3));
    finish_run();

    // Alternate-position pattern over 1000 items
    s = 8'($urandom_range(0, 255));
    start_run(s, 16'd1000, 8'b01010101, 1);
    wait_done(1000, 5000, 0, cyc);
    check("cycles_alt", cyc, done_cycles(8'b01010101, 1000));
    finish_run();

    // Random patterns, consumer always ready
    for (int r = 0; r < 3; r++) begin
      s = 8'($urandom_range(0, 255));
      pat = 8'($urandom_range(1, 255));
      n = 16'($urandom_range(1, 30));
      start_run(s, n, pat, 1);
      wait_done(int'(n), 1000, 0, cyc);
      check("cycles_rand_pat", cyc, done_cycles(pat, int'(n)));
      finish_run();
    end

    // Random patterns and random consumer backpressure
    for (int r = 0; r < 4; r++) begin
      s = 8'($urandom_range(0, 255));
      pat = 8'($urandom_range(1, 255));
      n = 16'($urandom_range(1, 40));
      start_run(s, n, pat, 1);
      wait_done(int'(n), 2000, 1, cyc);
      p_drdy = 1'b1;
      finish_run();
    end

    // Stall 5 cycles with offer pending
    p_drdy = 1'b0;
    start_run(8'h40, 16'd2, 8'hFF, 1);
    wait_srdy();
    repeat (5) begin
      tick();
      check("stall_srdy", p_srdy, 1);
      check("stall_data", p_data, 8'h40);
    end
    p_drdy = 1'b1;
    wait_done(2, 100, 0, cyc);
    finish_run();

    // Unlimited run, gen_en dropped while offer pending
    s = 8'($urandom_range(0, 255));
    start_run(s, 16'd0, 8'hFF, 0);
    push_items(s, 0, 10);
    wait_queue_drain(100);
    check("unl_srdy", p_srdy, 1);
    check("unl_no_done", done, 0);
    p_drdy = 1'b0;
    gen_en = 1'b0;
    tick();
    check("drop_held_srdy", p_srdy, 1);
    check("drop_held_state", state_dbg, ST_RUN);
    push_items(s, 10, 1);
    p_drdy = 1'b1;
    tick();
    check("drop_idle_state", state_dbg, ST_IDLE);
    check("drop_idle_srdy", p_srdy, 0);
    check("drop_queue_empty", exp_q.size(), 0);

    // All-zero pattern never offers
    x0 = xfers;
    start_run(8'h77, 16'd3, 8'h00, 0);
    repeat (20) tick();
    check("zero_pat_srdy", p_srdy, 0);
    check("zero_pat_xfers", xfers, x0);
    check("zero_pat_state", state_dbg, ST_RUN);
    gen_en = 1'b0;
    tick();
    check("zero_pat_idle", state_dbg, ST_IDLE);

    // Asynchronous reset mid-run with an offer pending
    s = 8'h20;
    start_run(s, 16'd0, 8'hFF, 0);
    push_items(s, 0, 3);
    wait_queue_drain(50);
    p_drdy = 1'b0;
    tick();
    check("pre_rst_srdy", p_srdy, 1);
    check("pre_rst_sent", sent_cnt, 3);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("arst_srdy", p_srdy, 0);
    check("arst_sent", sent_cnt, 0);
    check("arst_data", p_data, 0);
    check("arst_done", done, 0);
    check("arst_state", state_dbg, ST_IDLE);
    gen_en = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    repeat (3) tick();
    check("post_rst_idle", state_dbg, ST_IDLE);
    check("post_rst_srdy", p_srdy, 0);

    check("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sd_seq_gen.md
SD_SEQ_GEN -- requirements
Module: sd_seq_gen

Interface
REQ-001 Parameter width, default 8, data bus width in bits.
REQ-002 Parameter pat_dep, default 8, srdy throttle pattern depth.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 gen_en  input  1  level run request.
REQ-006 gen_count  input  16  items to send per run; 0 = unlimited.
REQ-007 seed  input  width  first data value of a run.
REQ-008 srdy_pat  input  pat_dep  throttle pattern; bit=1 permits srdy assertion.
REQ-009 p_srdy  output  1  producer data valid.
REQ-010 p_drdy  input  1  consumer ready.
REQ-011 p_data  output  width  incrementing sequence data.
REQ-012 sent_cnt  output  16  transfers completed this run.
REQ-013 done  output  1  run of gen_count items complete.

Function
REQ-014 All outputs SHALL be registered; states IDLE, RUN, DONE.
REQ-015 Transfer SHALL be defined as p_srdy & p_drdy at a rising clk edge.
REQ-016 IDLE with gen_en=1 SHALL, next edge: go to RUN, load p_data=seed, clear sent_cnt, clear pattern pointer ptr, keep p_srdy=0.
REQ-017 In RUN, when p_srdy=0 or a transfer occurs, next p_srdy SHALL equal srdy_pat[ptr] and ptr SHALL advance modulo pat_dep.
REQ-018 In RUN, p_srdy=1 with p_drdy=0 SHALL hold p_srdy, p_data and ptr unchanged (no retraction, no data change).
REQ-019 Each transfer SHALL increment p_data by 1 modulo 2^width (wraps max->0) and sent_cnt by 1 modulo 2^16.
REQ-020 Transfer making sent_cnt equal non-zero gen_count SHALL go to DONE with p_srdy=0 next cycle; done=1 in DONE.
REQ-021 gen_count=0 SHALL run indefinitely; sent_cnt wraps.
REQ-022 gen_en=0 in RUN SHALL return to IDLE only at the first edge where p_srdy=0 or a transfer occurs, then p_srdy=0.
REQ-023 DONE SHALL hold p_srdy=0 and done=1 until gen_en=0, then go to IDLE and clear done.
REQ-024 srdy_pat all zeros SHALL keep p_srdy=0 in RUN indefinitely; all ones SHALL allow back-to-back transfers at 1 item/cycle.
REQ-025 gen_count, seed SHALL be sampled only at IDLE->RUN; srdy_pat SHALL be sampled at every ptr advance.

Reset
REQ-026 reset=0 SHALL asynchronously force IDLE, p_srdy=0, p_data=0, sent_cnt=0, done=0, ptr=0.
REQ-027 Reset mid-transfer SHALL drop p_srdy immediately; after release a new run needs gen_en in IDLE.

Configuration
REQ-028 SD_SEQ_GEN_LFSR_EN defined: throttle bit SHALL come from bit 0 of an internal 16-bit Fibonacci LFSR (taps 16,14,13,11, reset value 16'hACE1, stepped on each ptr advance) and srdy_pat is ignored.
REQ-029 SD_SEQ_GEN_LFSR_EN undefined: throttle SHALL use srdy_pat[ptr]; no LFSR logic present.

Structure
REQ-030 Shared package SHALL hold the state enum (IDLE/RUN/DONE), LFSR reset value and tap constants.
REQ-031 LFSR SHALL be a sub-module sd_lfsr16 (enable in, state out), instantiated only under SD_SEQ_GEN_LFSR_EN.

Verification
REQ-032 seed=8'h10, gen_count=4, srdy_pat=all ones, p_drdy=1 -> data 10,11,12,13 on 4 consecutive cycles, then done=1, p_srdy=0.
REQ-033 seed=8'hFE, gen_count=3, p_drdy=1 -> data FE,FF,00; sent_cnt=3.
REQ-034 p_drdy=0 for 5 cycles while p_srdy=1 -> p_srdy and p_data stable all 5 cycles, then transfer.
REQ-035 srdy_pat=8'b01010101, p_drdy=1, gen_count=0 -> p_srdy asserts on alternate pattern positions; data strictly incrementing; downstream sd_seq_check reports no errors over 1000 items.
REQ-036 gen_en dropped while p_srdy=1, p_drdy=0 -> p_srdy held until p_drdy=1 transfer, then IDLE.
REQ-037 reset=0 pulse mid-run with p_srdy=1 -> p_srdy=0 asynchronously, sent_cnt=0, done=0.
